// File: rtl/sift_align.sv
// Delay-align a sample stream through a 2^AW ring buffer and subtract the
// matching envelope mean, producing a saturated 16-bit result.
module sift_align #(
  parameter int unsigned AW      = 6,
  parameter int unsigned DLY_RST = 30
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Xin_VALID,
  input  logic [15:0]   Xin,
  input  logic [AW-1:0] DELAY,
  input  logic          Mean_VALID,
  input  logic [15:0]   Mean,
  output logic [15:0]   Xin_DELAY,
  output logic          DELAY_VALID,
  output logic [15:0]   Hout,
  output logic          Hout_VALID,
  output logic          SAT,
  output logic          MISALIGN
);

  localparam int unsigned DW    = 16;
  localparam int unsigned FW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);
  localparam logic [DW-1:0] POS_MAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] NEG_MIN  = {1'b1, {(DW-1){1'b0}}};

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] dly;
  logic [FW-1:0] fill;

  logic          dly_change_c;
  logic          emit_c;
  logic          pair_c;
  logic [AW-1:0] rd_addr_c;
  logic [DW-1:0] tap_c;
  logic [DW:0]   diff_c;
  logic          sat_c;
  logic [DW-1:0] clamp_c;

  // Tap selection, emit decision and saturating subtract
  always_comb begin
    dly_change_c = 1'b0;
    emit_c       = 1'b0;
    pair_c       = 1'b0;
    rd_addr_c    = '0;
    tap_c        = '0;
    diff_c       = '0;
    sat_c        = 1'b0;
    clamp_c      = '0;

    dly_change_c = (DELAY != dly);
    emit_c       = Xin_VALID && !dly_change_c && (fill >= {1'b0, dly});
    rd_addr_c    = wp - dly;
    // A zero delay reads the word being written this cycle, so bypass the array
    tap_c        = (dly == '0) ? Xin : mem[rd_addr_c];

    pair_c  = DELAY_VALID && Mean_VALID;
    diff_c  = {Xin_DELAY[DW-1], Xin_DELAY} - {Mean[DW-1], Mean};
    sat_c   = diff_c[DW] ^ diff_c[DW-1];
    clamp_c = sat_c ? (diff_c[DW] ? NEG_MIN : POS_MAX) : diff_c[DW-1:0];
  end

  // Sample storage; contents are never emitted before being rewritten
  always_ff @(posedge CLK) begin
    if (Xin_VALID && !RST) begin
      mem[wp] <= Xin;
    end
  end

  // Write pointer, fill tracking and delayed-sample stage
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp          <= '0;
      fill        <= '0;
      dly         <= AW'(DLY_RST);
      Xin_DELAY   <= '0;
      DELAY_VALID <= 1'b0;
    end else begin
      dly         <= DELAY;
      DELAY_VALID <= emit_c;
      if (Xin_VALID) begin
        wp <= wp + AW'(1);
      end
      if (dly_change_c) begin
        fill <= Xin_VALID ? FW'(1) : '0;
      end else if (Xin_VALID && (fill != FILL_MAX)) begin
        fill <= fill + FW'(1);
      end
      if (emit_c) begin
        Xin_DELAY <= tap_c;
      end
    end
  end

  // Result stage and sticky handshake check
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Hout       <= '0;
      Hout_VALID <= 1'b0;
      SAT        <= 1'b0;
      MISALIGN   <= 1'b0;
    end else begin
      Hout_VALID <= pair_c;
      SAT        <= pair_c && sat_c;
      if (pair_c) begin
        Hout <= clamp_c;
      end
      if (DELAY_VALID != Mean_VALID) begin
        MISALIGN <= 1'b1;
      end
    end
  end

endmodule
